ltssm_main_sequencer: RTL and testbench
=======================================

Name: ltssm_main_sequencer

Overview:
Top-level link-training sequencer. It drives the shared substate code to the master RX and TX sub-LTSSMs, waits for both to report finish, reconciles their exit targets, and issues the next substate. It owns retry counting, the skew watchdog between the two finish reports, and the link-up indication.

Parameters:
FAIL_CNT_W, 3, width of consecutive-failure counter
MAX_RETRIES, 3'd4, consecutive failures that trigger training abort (must be < 2^FAIL_CNT_W)
SKEW_MAX, 8'd200, max cycles between first and second finish before declaring failure (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low
link_enable  input  1  level; 1 = train link, 0 = park and idle
retrain_req  input  1  single-cycle pulse; honoured only in LINKUP
rx_finish  input  1  single-cycle pulse from RX sub-LTSSM
rx_exit_to  input  4  RX exit target; valid with rx_finish
tx_finish  input  1  single-cycle pulse from TX sub-LTSSM
tx_exit_to  input  4  TX exit target; valid with tx_finish
substate  output  4  request code to both sub-LTSSMs
link_up  output  1  1 while in LINKUP
train_fail  output  1  sticky abort flag
fail_count  output  FAIL_CNT_W  consecutive failure count

Behaviour:
- Codes: detectQuiet=0, detectActive=1, pollingActive=2, pollingConfiguration=3, cfgLinkWidthStart=4, cfgLinkWidthAccept=5, cfgLanenumWait=6, cfgLanenumAccept=7, cfgComplete=8, cfgIdle=9, L0=10, PARK=4'hF (no request; sub-LTSSMs rearm on it).
- Reset values: substate=F, link_up=0, train_fail=0, fail_count=0, state IDLE, target=0, flags/skew counter cleared. Reset mid-operation aborts immediately to these values.
- States: IDLE, PARK, WAIT, LINKUP, ABORT. All outputs registered.
- IDLE: substate=F. link_enable=1 -> PARK with target=0.
- PARK: substate=F for exactly one cycle, then WAIT with substate=target (target=10 -> LINKUP with substate=10, link_up=1, fail_count=0).
- WAIT: substate=target held stable. rx_finish/tx_finish set rx_done/tx_done and capture exit codes. First finish starts skew counter at 0, incrementing each cycle. Both finishes in the same cycle allowed.
- Decision, at the edge where both done (registered or same cycle): success iff rx_exit==tx_exit==target+1 -> target=target+1. Otherwise (either exit=0, codes disagree, code>10, or code!=target+1) failure -> target=0, fail_count+1. Then -> PARK, flags cleared. Substate=F from that edge; new request visible one cycle later.
- Skew timeout: skew counter reaches SKEW_MAX with one flag still clear -> failure, as above. A finish arriving in the same cycle as the timeout counts as completion (finish wins).
- Success does not clear fail_count; only reaching L0 clears it.
- Failure making fail_count==MAX_RETRIES -> ABORT instead of PARK: substate=F, train_fail=1. Exit only when link_enable=0 -> IDLE, fail_count=0, train_fail=0.
- LINKUP: substate=10, link_up=1; finish pulses ignored. retrain_req -> PARK, target=0, link_up=0 next cycle; fail_count unchanged.
- link_enable=0 in PARK/WAIT/LINKUP -> IDLE next edge, substate=F, link_up=0, flags cleared, fail_count=0. Takes priority over finish/retrain in the same cycle.
- Finish pulses in IDLE/PARK/ABORT are ignored.

Test Plan:
- Happy path: link_enable=1, both finish same cycle with exit=substate+1 every request -> substate 0,F,1,F,...,9,F,10; link_up=1 one cycle after the final F; fail_count=0.
- Skew: at substate=2, rx_finish(exit 3), tx_finish(exit 3) 5 cycles later -> substate stays 2 for those 5 cycles, then F, then 3.
- Disagreement: at substate=4, rx exit 5, tx exit 0 -> F then 0, fail_count=1.
- Skew timeout: SKEW_MAX=8, only rx_finish at substate=3 -> F 8 cycles after rx_finish, then 0, fail_count=1.
- Abort: 4 consecutive failures -> train_fail=1, substate=F held; link_enable=0 -> IDLE, fail_count=0, train_fail=0.
- Retrain/reset: retrain_req in LINKUP -> link_up=0, F, 0. Assert reset mid-WAIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ltssm_main_sequencer.sv
// Top-level link-training sequencer: issues substate requests to the RX/TX sub-LTSSMs,
// reconciles their finish reports, and tracks retries, skew timeout and link-up.
module ltssm_main_sequencer #(
    parameter int unsigned           FAIL_CNT_W  = 3,
    parameter logic [FAIL_CNT_W-1:0] MAX_RETRIES = FAIL_CNT_W'(4),
    parameter logic [7:0]            SKEW_MAX    = 8'd200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  link_enable,
    input  logic                  retrain_req,
    input  logic                  rx_finish,
    input  logic [3:0]            rx_exit_to,
    input  logic                  tx_finish,
    input  logic [3:0]            tx_exit_to,
    output logic [3:0]            substate,
    output logic                  link_up,
    output logic                  train_fail,
    output logic [FAIL_CNT_W-1:0] fail_count
);

    localparam logic [3:0] SubPark = 4'hF;
    localparam logic [3:0] SubL0   = 4'd10;

    typedef enum logic [2:0] {StIdle, StPark, StWait, StLinkup, StAbort} state_e;

    state_e                state_q, state_d;
    logic [3:0]            target_q, target_d;
    logic [3:0]            substate_q, substate_d;
    logic                  link_up_q, link_up_d;
    logic                  train_fail_q, train_fail_d;
    logic [FAIL_CNT_W-1:0] fail_count_q, fail_count_d;
    logic                  rx_done_q, rx_done_d, tx_done_q, tx_done_d;
    logic [3:0]            rx_exit_q, rx_exit_d, tx_exit_q, tx_exit_d;
    logic [7:0]            skew_q, skew_d;

    logic                  rx_done_n, tx_done_n;
    logic [3:0]            rx_code, tx_code;
    logic                  decide, success, go_idle;
    logic [FAIL_CNT_W-1:0] fail_next;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        substate_d   = substate_q;
        link_up_d    = link_up_q;
        train_fail_d = train_fail_q;
        fail_count_d = fail_count_q;
        rx_done_d    = rx_done_q;
        tx_done_d    = tx_done_q;
        rx_exit_d    = rx_exit_q;
        tx_exit_d    = tx_exit_q;
        skew_d       = skew_q;
        decide       = 1'b0;
        success      = 1'b0;
        go_idle      = 1'b0;
        fail_next    = fail_count_q + FAIL_CNT_W'(1);
        // A finish in the current cycle counts together with any already recorded one.
        rx_done_n    = rx_done_q | rx_finish;
        tx_done_n    = tx_done_q | tx_finish;
        rx_code      = rx_finish ? rx_exit_to : rx_exit_q;
        tx_code      = tx_finish ? tx_exit_to : tx_exit_q;

        case (state_q)
            StIdle: begin
                substate_d = SubPark;
                link_up_d  = 1'b0;
                if (link_enable) begin
                    state_d  = StPark;
                    target_d = 4'd0;
                end
            end
            StPark: begin
                if (!link_enable) begin
                    go_idle = 1'b1;
                end else if (target_q == SubL0) begin
                    state_d      = StLinkup;
                    substate_d   = SubL0;
                    link_up_d    = 1'b1;
                    fail_count_d = '0;
                end else begin
                    state_d    = StWait;
                    substate_d = target_q;
                end
            end
            StWait: begin
                if (!link_enable) begin
                    go_idle = 1'b1;
                end else begin
                    rx_done_d = rx_done_n;
                    tx_done_d = tx_done_n;
                    rx_exit_d = rx_code;
                    tx_exit_d = tx_code;
                    if (rx_done_n && tx_done_n) begin
                        decide  = 1'b1;
                        // target never exceeds 9 here, so target+1 cannot wrap.
                        success = (rx_code == tx_code) && (rx_code == target_q + 4'd1);
                    end else if (rx_done_q || tx_done_q) begin
                        if (skew_q == SKEW_MAX - 8'd1) begin
                            decide = 1'b1;
                        end else begin
                            skew_d = skew_q + 8'd1;
                        end
                    end else if (rx_done_n || tx_done_n) begin
                        skew_d = 8'd0;
                    end
                end
            end
            StLinkup: begin
                if (!link_enable) begin
                    go_idle = 1'b1;
                end else if (retrain_req) begin
                    state_d    = StPark;
                    target_d   = 4'd0;
                    substate_d = SubPark;
                    link_up_d  = 1'b0;
                end
            end
            StAbort: begin
                substate_d = SubPark;
                if (!link_enable) begin
                    state_d      = StIdle;
                    fail_count_d = '0;
                    train_fail_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (decide) begin
            state_d    = StPark;
            substate_d = SubPark;
            rx_done_d  = 1'b0;
            tx_done_d  = 1'b0;
            skew_d     = 8'd0;
            if (success) begin
                target_d = target_q + 4'd1;
            end else begin
                target_d     = 4'd0;
                fail_count_d = fail_next;
                if (fail_next == MAX_RETRIES) begin
                    state_d      = StAbort;
                    train_fail_d = 1'b1;
                end
            end
        end

        if (go_idle) begin
            state_d      = StIdle;
            substate_d   = SubPark;
            link_up_d    = 1'b0;
            rx_done_d    = 1'b0;
            tx_done_d    = 1'b0;
            skew_d       = 8'd0;
            fail_count_d = '0;
            train_fail_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            target_q     <= 4'd0;
            substate_q   <= SubPark;
            link_up_q    <= 1'b0;
            train_fail_q <= 1'b0;
            fail_count_q <= '0;
            rx_done_q    <= 1'b0;
            tx_done_q    <= 1'b0;
            rx_exit_q    <= 4'd0;
            tx_exit_q    <= 4'd0;
            skew_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            substate_q   <= substate_d;
            link_up_q    <= link_up_d;
            train_fail_q <= train_fail_d;
            fail_count_q <= fail_count_d;
            rx_done_q    <= rx_done_d;
            tx_done_q    <= tx_done_d;
            rx_exit_q    <= rx_exit_d;
            tx_exit_q    <= tx_exit_d;
            skew_q       <= skew_d;
        end
    end

    assign substate   = substate_q;
    assign link_up    = link_up_q;
    assign train_fail = train_fail_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_ltssm_main_sequencer.sv
// Bench for ltssm_main_sequencer: directed scenarios plus random request outcomes, checked
// against a request-level model of the training rules.
module tb_ltssm_main_sequencer;

    localparam int SKEW = 8;
    localparam int MAXR = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       link_enable;
    logic       retrain_req;
    logic       rx_finish;
    logic [3:0] rx_exit_to;
    logic       tx_finish;
    logic [3:0] tx_exit_to;
    logic [3:0] substate;
    logic       link_up;
    logic       train_fail;
    logic [2:0] fail_count;

    int checks = 0;
    int errors = 0;

    // Request-level model.
    int m_target;
    int m_fail;
    bit m_abort;
    bit m_linkup;

    ltssm_main_sequencer #(
        .FAIL_CNT_W (3),
        .MAX_RETRIES(3'd4),
        .SKEW_MAX   (8'(SKEW))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .link_enable(link_enable),
        .retrain_req(retrain_req),
        .rx_finish  (rx_finish),
        .rx_exit_to (rx_exit_to),
        .tx_finish  (tx_finish),
        .tx_exit_to (tx_exit_to),
        .substate   (substate),
        .link_up    (link_up),
        .train_fail (train_fail),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int sub, input int lu, input int tf,
                           input int fc);
        chk({tag, ".substate"}, 32'(substate), sub);
        chk({tag, ".link_up"}, 32'(link_up), lu);
        chk({tag, ".train_fail"}, 32'(train_fail), tf);
        chk({tag, ".fail_count"}, 32'(fail_count), fc);
    endtask

    task automatic start_link();
        link_enable = 1'b1;
        @(negedge clk);
        chk_all("start_park", 15, 0, 0, m_fail);
        @(negedge clk);
        chk("start_first_req", 32'(substate), 0);
        m_target = 0;
        m_abort  = 1'b0;
        m_linkup = 1'b0;
    endtask

    task automatic drop_enable();
        link_enable = 1'b0;
        @(negedge clk);
        chk_all("disable", 15, 0, 0, 0);
        m_fail   = 0;
        m_target = 0;
        m_abort  = 1'b0;
        m_linkup = 1'b0;
    endtask

    task automatic retrain();
        retrain_req = 1'b1;
        @(negedge clk);
        retrain_req = 1'b0;
        chk_all("retrain_park", 15, 0, 0, m_fail);
        @(negedge clk);
        chk_all("retrain_req0", 0, 0, 0, m_fail);
        m_target = 0;
        m_linkup = 1'b0;
    endtask

    // Stable outputs in LINKUP/ABORT while stray finish pulses arrive.
    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            rx_finish  = 1'($urandom_range(0, 1));
            tx_finish  = 1'($urandom_range(0, 1));
            rx_exit_to = 4'($urandom_range(0, 15));
            tx_exit_to = 4'($urandom_range(0, 15));
            @(negedge clk);
            if (m_linkup) chk_all("hold_linkup", 10, 1, 0, 0);
            else          chk_all("hold_abort", 15, 0, 1, m_fail);
        end
        rx_finish = 1'b0;
        tx_finish = 1'b0;
    endtask

    // Offsets are cycles after the request first appears; -1 = never finishes.
    task automatic req(input int rx_off, input int rx_code, input int tx_off, input int tx_code);
        int d;
        int lo;
        int hi;
        bit both;
        bit ok;
        both = 1'b0;
        if (rx_off >= 0 && tx_off >= 0) begin
            lo = (rx_off < tx_off) ? rx_off : tx_off;
            hi = (rx_off < tx_off) ? tx_off : rx_off;
            if (hi - lo <= SKEW) begin
                d    = hi;
                both = 1'b1;
            end else begin
                d = lo + SKEW;
            end
        end else begin
            d = ((rx_off >= 0) ? rx_off : tx_off) + SKEW;
        end
        for (int k = 0; k <= d; k++) begin
            chk("wait_substate", 32'(substate), m_target);
            rx_finish  = (rx_off == k);
            rx_exit_to = (rx_off == k) ? 4'(rx_code) : 4'($urandom_range(0, 15));
            tx_finish  = (tx_off == k);
            tx_exit_to = (tx_off == k) ? 4'(tx_code) : 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        rx_finish = 1'b0;
        tx_finish = 1'b0;
        ok = both && (rx_code == tx_code) && (rx_code == m_target + 1);
        if (ok) begin
            m_target++;
        end else begin
            m_target = 0;
            m_fail++;
        end
        m_abort = !ok && (m_fail == MAXR);
        chk_all("decision_park", 15, 0, int'(m_abort), m_fail);
        @(negedge clk);
        if (m_abort) begin
            chk_all("abort", 15, 0, 1, m_fail);
        end else if (m_target == 10) begin
            m_fail   = 0;
            m_linkup = 1'b1;
            chk_all("linkup", 10, 1, 0, 0);
        end else begin
            chk_all("next_req", m_target, 0, 0, m_fail);
        end
    endtask

    task automatic random_req();
        int ro;
        int to;
        int rc;
        int tc;
        int t;
        rc = ($urandom_range(0, 9) < 8) ? m_target + 1 : int'($urandom_range(0, 15));
        tc = ($urandom_range(0, 9) < 8) ? m_target + 1 : int'($urandom_range(0, 15));
        ro = int'($urandom_range(0, 3));
        to = ($urandom_range(0, 9) == 0) ? -1 : ro + int'($urandom_range(0, 10));
        if (to >= 0 && $urandom_range(0, 1) == 1) begin
            t  = ro;
            ro = to;
            to = t;
        end
        req(ro, rc, to, tc);
    endtask

    initial begin
        reset       = 1'b1;
        link_enable = 1'b0;
        retrain_req = 1'b0;
        rx_finish   = 1'b0;
        tx_finish   = 1'b0;
        rx_exit_to  = 4'd0;
        tx_exit_to  = 4'd0;
        m_target    = 0;
        m_fail      = 0;
        m_abort     = 1'b0;
        m_linkup    = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 15, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_all("idle_disabled", 15, 0, 0, 0);

        // Happy path up to L0.
        start_link();
        for (int i = 0; i < 10; i++) begin
            int off = int'($urandom_range(0, 3));
            req(off, m_target + 1, off, m_target + 1);
        end
        hold(3);
        retrain();

        // Skew within limit, disagreement, then skew timeout.
        req(0, 1, 0, 1);
        req(0, 2, 0, 2);
        req(0, 3, 5, 3);
        req(0, 4, 0, 4);
        req(0, 5, 0, 0);
        req(0, 1, 0, 1);
        req(0, 2, 0, 2);
        req(0, 3, 0, 3);
        req(0, 4, -1, 0);

        // Four consecutive failures of different kinds lead to abort.
        drop_enable();
        start_link();
        req(0, 0, 0, 0);
        req(1, 3, 1, 3);
        req(-1, 0, 0, 1);
        req(0, 15, 2, 15);
        hold(3);
        drop_enable();

        // Disable wins over finishes arriving in the same cycle.
        start_link();
        req(0, 1, 0, 1);
        link_enable = 1'b0;
        rx_finish   = 1'b1;
        tx_finish   = 1'b1;
        rx_exit_to  = 4'd2;
        tx_exit_to  = 4'd2;
        @(negedge clk);
        rx_finish = 1'b0;
        tx_finish = 1'b0;
        chk_all("disable_beats_finish", 15, 0, 0, 0);
        m_fail = 0;
        @(negedge clk);
        chk_all("idle_after_disable", 15, 0, 0, 0);
        start_link();

        // Random phase.
        for (int i = 0; i < 60; i++) begin
            if (m_abort) begin
                hold(2);
                drop_enable();
                start_link();
            end else if (m_linkup) begin
                hold(int'($urandom_range(1, 3)));
                if ($urandom_range(0, 1) == 1) begin
                    retrain();
                end else begin
                    drop_enable();
                    start_link();
                end
            end else begin
                random_req();
            end
        end

        // Asynchronous reset in the middle of WAIT.
        drop_enable();
        start_link();
        req(0, 1, 0, 1);
        req(1, 2, -1, 0);
        rx_finish  = 1'b1;
        rx_exit_to = 4'd1;
        #2 reset = 1'b0;
        #1 chk_all("async_reset", 15, 0, 0, 0);
        rx_finish = 1'b0;
        @(negedge clk);
        chk_all("reset_held", 15, 0, 0, 0);
        reset  = 1'b1;
        m_fail = 0;
        start_link();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
